mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Data-memory access sequencer for the MIPS64 datapath, sitting directly downstream of the main decoder. It consumes the decoder's `memwrite`, `memread` and `readtype` controls together with the ALU-computed address and store data. It runs each load/store as one or two beats on a 32-bit req/ack memory bus and returns a sign/zero-extended 64-bit load result with a one-cycle `done` pulse. The datapath stalls while `busy` is high.

## Interface
- `BUS_AW`, 32: bus byte-address width; `addr` is truncated to this width.
- `clk` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request valid; sampled only in IDLE.
- `memwrite` in 2: 00 none, 01 SW, 10 SB, 11 SD.
- `memread` in 1: load request.
- `readtype` in 3: 000 LW, 001 LWU, 010 LB, 011 LBU, 100 LD; other codes are treated as LW.
- `addr` in 64: byte address.
- `wdata` in 64: store data.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: qualifies `done`; access aborted.
- `rdata` out 64: extended load result, held between loads.
- `bus_req` out 1: beat request.
- `bus_we` out 1: write beat.
- `bus_addr` out BUS_AW: word-aligned address ({addr[BUS_AW-1:2],2'b00}).
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: write lane data.
- `bus_rdata` in 32: read data, valid with `bus_ack`.
- `bus_ack` in 1: beat completes at a rising edge where `bus_req && bus_ack`.

## Operation
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE + `start`:
  - If `memwrite==0 && !memread`, the request is ignored; stay IDLE, no `done`.
  - If `memwrite≠0`, the access is a write, even if `memread` is also high.
  - Otherwise the access is a read.
- Latch op, addr and wdata on accept. Inputs are don't-care afterwards.
- Alignment rules: SD/LD need addr[2:0]=0; SW/LW/LWU need addr[1:0]=0; bytes are unrestricted.
- Misaligned access: go to DONE with `misalign=1`. No bus beat is issued; `rdata` is unchanged.
- BEAT0:
  - `bus_req=1`, `bus_we` per op.
  - Word access: `bus_be=1111`, data = low word.
  - Byte access: `bus_be = 4'b1 << addr[1:0]`, `bus_wdata = {4{wdata[7:0]}}`.
  - Doubleword beat 0: low word at addr.
  - On ack: doubleword goes to BEAT1; all others go to DONE.
- BEAT1: high word at addr+4, `bus_be=1111`; on ack go to DONE. Layout is little-endian.
- Read capture on each read ack:
  - LB/LBU take byte lane addr[1:0]; LB sign-extends, LBU zero-extends.
  - LW sign-extends; LWU zero-extends.
  - LD = {beat1 word, beat0 word}.
  - `rdata` updates at the edge entering DONE.
- DONE: `done=1` for one cycle, then IDLE. `start` is ignored in DONE.
- `bus_ack` while `bus_req=0` is ignored.
- Bus outputs stay stable while `bus_req` is high and un-acked.
- Reset values: state IDLE; `busy`, `done`, `misalign`, `bus_req`, `bus_we` are 0; `bus_be=0`; `bus_addr`, `bus_wdata`, `rdata` are 0.
- Reset mid-beat: the beat is abandoned and `bus_req` falls at the reset edge. No `done` is produced.

## Timing
- All outputs are registered or decoded from state only; no combinational path from `bus_ack` to outputs.
- Accept edge E: `busy` and `bus_req` are high from E onward.
- Zero-wait single-beat access: ack sampled at E+1, `done` high in cycle E+1..E+2. Latency is 2 cycles start-to-done.
- Doubleword: `bus_req` stays high continuously across beats; `bus_addr` advances at the BEAT0 ack edge. Zero-wait latency is 3 cycles.
- Wait states add one cycle each.
- Misaligned access: `done`/`misalign` pulse in the cycle after accept.
- Earliest next accept is the cycle after `done`.

## Structure
- Package `mem_pkg`:
  - `memwrite` encodings MW_NONE/MW_W/MW_B/MW_D.
  - `readtype` encodings RT_LW/RT_LWU/RT_LB/RT_LBU/RT_LD.
  - State enum `mac_state_t`.
- Sub-module `load_extend`: combinational. Inputs are readtype, byte offset, and beat words; output is the 64-bit result.

## Test plan
- SW: addr=0x1004, wdata=0x…_DEADBEEF, immediate ack → one beat, bus_addr=0x1004, be=1111, wdata=0xDEADBEEF, `done` two cycles after start.
- SB: addr=0x1003, wdata[7:0]=0xA5 → be=1000, bus_wdata=0xA5A5A5A5.
- LB then LBU: addr=0x2002, bus_rdata=0x00F00000 → rdata=0xFFFF_FFFF_FFFF_FFF0, then 0x0000_0000_0000_00F0.
- LD: addr=0x3000, beats return 0x11223344 then 0x8899AABB, with 2 wait states on beat 1 → addrs 0x3000/0x3004, req continuous, rdata=0x8899AABB11223344.
- Misaligned SD: addr=0x3004 → no `bus_req`, done+misalign next cycle, rdata unchanged. A start with memwrite=0, memread=0 produces no activity.
- Reset asserted during a waiting LW beat → `bus_req` and `busy` drop at the reset edge, no `done`. A later ack is ignored.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_pkg: decoder encodings, sequencer state and access-size helpers for mem_access_ctrl.
package mem_pkg;

   localparam logic [1:0] MW_NONE = 2'b00;
   localparam logic [1:0] MW_W    = 2'b01;
   localparam logic [1:0] MW_B    = 2'b10;
   localparam logic [1:0] MW_D    = 2'b11;

   localparam logic [2:0] RT_LW  = 3'b000;
   localparam logic [2:0] RT_LWU = 3'b001;
   localparam logic [2:0] RT_LB  = 3'b010;
   localparam logic [2:0] RT_LBU = 3'b011;
   localparam logic [2:0] RT_LD  = 3'b100;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_W = 2'd1;
   localparam logic [1:0] SZ_D = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} mac_state_t;

   function automatic logic [1:0] access_size(input logic wr, input logic [1:0] mw, input logic [2:0] rt);
      if (wr) return mw == MW_D ? SZ_D : mw == MW_B ? SZ_B : SZ_W;
      return rt == RT_LD ? SZ_D : (rt == RT_LB || rt == RT_LBU) ? SZ_B : SZ_W;
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
      return sz == SZ_D ? a != 3'b000 : sz == SZ_W ? a[1:0] != 2'b00 : 1'b0;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// load_extend: selects and sign/zero-extends load data from one or two 32-bit beat words.
module load_extend
   import mem_pkg::*;
(
   input  logic [2:0]  readtype,
   input  logic [1:0]  offset,
   input  logic [31:0] w0,
   input  logic [31:0] w1,
   output logic [63:0] result
);
   logic [7:0] b;
   always_comb begin
      b = w0[{offset, 3'b000} +: 8];
      result = readtype == RT_LB  ? {{56{b[7]}}, b} :
               readtype == RT_LBU ? {56'd0, b} :
               readtype == RT_LWU ? {32'd0, w0} :
               readtype == RT_LD  ? {w1, w0} :
                                    {{32{w0[31]}}, w0};
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: runs decoded loads/stores as one or two req/ack beats on a 32-bit memory bus
// and returns an extended 64-bit load result with a single-cycle done pulse.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int BUS_AW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        memwrite,
   input  logic              memread,
   input  logic [2:0]        readtype,
   input  logic [63:0]       addr,
   input  logic [63:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              misalign,
   output logic [63:0]       rdata,
   output logic              bus_req,
   output logic              bus_we,
   output logic [BUS_AW-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack
);
   mac_state_t        state_q, state_d;
   logic              we_q, we_d, mis_q, mis_d;
   logic [1:0]        sz_q, sz_d;
   logic [2:0]        rt_q, rt_d;
   logic [BUS_AW-1:0] addr_q, addr_d;
   logic [63:0]       wdata_q, wdata_d, rdata_q, rdata_d, ext;
   logic [31:0]       lo_q, lo_d;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^addr[63:BUS_AW];

   load_extend u_ext (
      .readtype(rt_q),
      .offset  (addr_q[1:0]),
      .w0      (state_q == S_BEAT1 ? lo_q : bus_rdata),
      .w1      (bus_rdata),
      .result  (ext)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      mis_d   = mis_q;
      sz_d    = sz_q;
      rt_d    = rt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: if (start && (memwrite != MW_NONE || memread)) begin
            we_d    = memwrite != MW_NONE;
            sz_d    = access_size(we_d, memwrite, readtype);
            rt_d    = readtype;
            addr_d  = addr[BUS_AW-1:0];
            wdata_d = wdata;
            mis_d   = misaligned(sz_d, addr[2:0]);
            state_d = mis_d ? S_DONE : S_BEAT0;
         end
         S_BEAT0: if (bus_ack) begin
            lo_d    = we_q ? lo_q : bus_rdata;
            rdata_d = (we_q || sz_q == SZ_D) ? rdata_q : ext;
            state_d = sz_q == SZ_D ? S_BEAT1 : S_DONE;
         end
         S_BEAT1: if (bus_ack) begin
            rdata_d = we_q ? rdata_q : ext;
            state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         mis_q   <= 1'b0;
         sz_q    <= SZ_B;
         rt_q    <= RT_LW;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         mis_q   <= mis_d;
         sz_q    <= sz_d;
         rt_q    <= rt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         lo_q    <= lo_d;
      end
   end

   // Bus outputs derive from latched request and state only, so they hold while un-acked.
   assign busy      = state_q != S_IDLE;
   assign done      = state_q == S_DONE;
   assign misalign  = done && mis_q;
   assign rdata     = rdata_q;
   assign bus_req   = state_q == S_BEAT0 || state_q == S_BEAT1;
   assign bus_we    = bus_req && we_q;
   assign bus_addr  = bus_req ? {addr_q[BUS_AW-1:3], addr_q[2] | (state_q == S_BEAT1), 2'b00} : '0;
   assign bus_be    = !bus_req ? 4'b0000 : sz_q == SZ_B ? 4'b0001 << addr_q[1:0] : 4'b1111;
   assign bus_wdata = !(bus_req && we_q) ? 32'd0 :
                      sz_q == SZ_B ? {4{wdata_q[7:0]}} :
                      state_q == S_BEAT1 ? wdata_q[63:32] : wdata_q[31:0];
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed test-plan accesses plus randomized loads/stores checked against a byte-level model.
module tb_mem_access_ctrl;
   logic        clk = 1'b0;
   logic        reset, start, memread, bus_ack;
   logic [1:0]  memwrite;
   logic [2:0]  readtype;
   logic [63:0] addr, wdata, rdata;
   logic        busy, done, misalign, bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] m_rdata = '0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.BUS_AW(32)) dut (
      .clk(clk), .reset(reset), .start(start), .memwrite(memwrite), .memread(memread),
      .readtype(readtype), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .misalign(misalign), .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Drives one request from a negedge and follows it to completion, returning at a negedge in IDLE.
   task automatic access(input logic [1:0] mw, input logic mr, input logic [2:0] rt,
                         input logic [63:0] a, input logic [63:0] wd, input int wt0, input int wt1,
                         input logic [31:0] rd0, input logic [31:0] rd1);
      bit          wr = mw != 2'b00;
      int          size = wr ? (mw == 2'b11 ? 8 : mw == 2'b10 ? 1 : 4)
                             : (rt == 3'd4 ? 8 : (rt == 3'd2 || rt == 3'd3) ? 1 : 4);
      bit          mis = (a % size) != 0;
      int          nb = size == 8 ? 2 : 1;
      logic [31:0] base = 32'(a) & ~32'd3;
      logic [63:0] exp;
      logic [7:0]  b;
      start = 1'b1; memwrite = mw; memread = mr; readtype = rt; addr = a; wdata = wd;
      @(negedge clk);
      start = 1'b0; memwrite = 2'($urandom); memread = 1'($urandom);
      readtype = 3'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
      if (!wr && !mr) begin
         chk("ign_busy", busy, 0);
         chk("ign_req", bus_req, 0);
         chk("ign_done", done, 0);
         return;
      end
      if (mis) begin
         chk("mis_req", bus_req, 0);
         chk("mis_done", done, 1);
         chk("mis_flag", misalign, 1);
         chk("mis_rdata", rdata, m_rdata);
      end else begin
         for (int k = 0; k < nb; k++) begin
            for (int w = 0; w <= (k == 0 ? wt0 : wt1); w++) begin
               chk("req", bus_req, 1);
               chk("done_early", done, 0);
               chk("we", bus_we, wr);
               chk("baddr", bus_addr, base + 32'(4 * k));
               chk("be", bus_be, size == 1 ? 4'(1 << (a % 4)) : 4'hF);
               if (wr) chk("bwdata", bus_wdata, size == 1 ? 32'(wd[7:0]) * 32'h01010101 : 32'(wd >> (32 * k)));
               bus_ack = w == (k == 0 ? wt0 : wt1);
               bus_rdata = bus_ack ? (k == 0 ? rd0 : rd1) : $urandom;
               @(negedge clk);
               bus_ack = 1'b0;
            end
         end
         if (!wr) begin
            b = 8'(rd0 >> (8 * (a % 4)));
            exp = size == 8 ? {rd1, rd0} :
                  size == 1 ? (rt == 3'd2 ? 64'($signed(b)) : 64'(b)) :
                  rt == 3'd1 ? 64'(rd0) : 64'($signed(rd0));
            m_rdata = exp;
         end
         chk("done", done, 1);
         chk("mis_clr", misalign, 0);
         chk("req_off", bus_req, 0);
         chk("rdata", rdata, m_rdata);
      end
      start = 1'b1; memread = 1'b1; bus_ack = 1'($urandom);
      @(negedge clk);
      start = 1'b0; memread = 1'b0; memwrite = 2'b00; bus_ack = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
   endtask

   initial begin
      logic [63:0] ra;
      reset = 1'b1; start = 1'b0; memwrite = 2'b00; memread = 1'b0; readtype = 3'd0;
      addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mis", misalign, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_we", bus_we, 0);
      chk("rst_be", bus_be, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_wdata", bus_wdata, 0);
      chk("rst_rdata", rdata, 0);
      reset = 1'b0;
      @(negedge clk);
      access(2'b01, 1'b1, 3'd0, 64'h1004, 64'h0123_4567_DEAD_BEEF, 0, 0, 0, 0);
      access(2'b10, 1'b0, 3'd0, 64'h1003, 64'h0000_0000_0000_00A5, 0, 0, 0, 0);
      access(2'b00, 1'b1, 3'd2, 64'h2002, 0, 1, 0, 32'h00F0_0000, 0);
      chk("lb_val", rdata, 64'hFFFF_FFFF_FFFF_FFF0);
      access(2'b00, 1'b1, 3'd3, 64'h2002, 0, 0, 0, 32'h00F0_0000, 0);
      chk("lbu_val", rdata, 64'h0000_0000_0000_00F0);
      access(2'b00, 1'b1, 3'd4, 64'h3000, 0, 0, 2, 32'h1122_3344, 32'h8899_AABB);
      chk("ld_val", rdata, 64'h8899_AABB_1122_3344);
      access(2'b11, 1'b0, 3'd0, 64'h3004, 64'hFFFF, 0, 0, 0, 0);
      access(2'b00, 1'b0, 3'd0, 64'h3000, 0, 0, 0, 0, 0);
      for (int i = 0; i < 200; i++) begin
         ra = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) ra[2:0] = 3'b000;
         access(2'($urandom), 1'($urandom), 3'($urandom), ra, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
      end
      start = 1'b1; memread = 1'b1; readtype = 3'd0; addr = 64'h40;
      @(negedge clk);
      start = 1'b0; memread = 1'b0;
      chk("rst_mid_req", bus_req, 1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_req_drop", bus_req, 0);
      chk("rst_mid_busy_drop", busy, 0);
      m_rdata = '0;
      @(negedge clk);
      reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("rst_mid_nodone", done, 0);
      chk("rst_mid_idle", busy, 0);
      chk("rst_mid_rdata", rdata, m_rdata);
      access(2'b00, 1'b1, 3'd1, 64'h44, 0, 1, 0, 32'h8000_0001, 0);
      chk("lwu_val", rdata, 64'h0000_0000_8000_0001);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
